adc16dv160_output_emulator: RTL and testbench

- Transmit-side counterpart of the ADC16DV160 LVDS DDR input path. Lets the digitizer run loopback and bench tests without a real converter.
- Accepts 32-bit AXI-Stream words, each holding two 16-bit samples. Buffers them in an internal FIFO.
- Drives one sample per clock as 8 rising-edge bits and 8 falling-edge bits for external ODDR/OBUFDS.
- Provides a ramp test source, underflow accounting and a frame sync pulse.

---
 rtl/adc16dv160_output_emulator.sv | 170 +++++++++++++++++
 tb/tb_adc16dv160_output_emulator.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc16dv160_output_emulator.sv
// Transmit-side emulator for the ADC16DV160 LVDS DDR interface: buffers AXI-Stream sample
// pairs and drives one 16-bit sample per clock as rise/fall lane bits, with ramp test source.
module adc16dv160_output_emulator #(
  parameter int FIFO_DEPTH  = 16,
  parameter int PRIME_LEVEL = 4
) (
  input  logic        s00_axis_aclk,
  input  logic        s00_axis_aresetn,
  input  logic        s00_axis_tvalid,
  output logic        s00_axis_tready,
  input  logic [31:0] s00_axis_tdata,
  input  logic        s00_axis_tlast,
  input  logic        enable,
  input  logic        test_mode,
  input  logic [15:0] idle_value,
  output logic [7:0]  dout_rise,
  output logic [7:0]  dout_fall,
  output logic        sync_out,
  output logic        running,
  output logic [31:0] underflow_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DepthCnt = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] PrimeCnt = (AW+1)'(PRIME_LEVEL);

  typedef enum logic [1:0] {StIdle, StPrime, StRun} state_t;

  logic [32:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [AW:0]   count_q, count_d;
  logic          tready_q;
  logic          wrEn, rdEn;
  logic [32:0]   head;

  state_t        state_q, state_d;
  logic          half_q, half_d;
  logic          first_q, first_d;
  logic          prevLast_q, prevLast_d;
  logic          testMode_q, testMode_d;
  logic [15:0]   ramp_q, ramp_d;
  logic [31:0]   under_q, under_d;
  logic [15:0]   sample;
  logic          sampleSync;
  logic [7:0]    rise_q, fall_q, riseNext, fallNext;
  logic          sync_q;

  assign wrEn = s00_axis_tvalid && tready_q;
  assign head = mem[rdPtr_q];

  always_ff @(posedge s00_axis_aclk) begin
    if (wrEn) mem[wrPtr_q] <= {s00_axis_tlast, s00_axis_tdata};
  end

  always_comb begin
    case ({wrEn, rdEn})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A word's low half is emitted without popping; the pop happens on its high half.
  always_comb begin
    state_d    = state_q;
    half_d     = half_q;
    first_d    = first_q;
    prevLast_d = prevLast_q;
    testMode_d = testMode_q;
    ramp_d     = ramp_q;
    under_d    = under_q;
    sample     = idle_value;
    sampleSync = 1'b0;
    rdEn       = 1'b0;
    case (state_q)
      StIdle: begin
        ramp_d  = 16'h0000;
        first_d = 1'b1;
        if (enable) begin
          testMode_d = test_mode;
          state_d    = test_mode ? StRun : StPrime;
        end
      end
      StPrime: begin
        ramp_d  = 16'h0000;
        first_d = 1'b1;
        if (!enable) state_d = StIdle;
        else if (count_q >= PrimeCnt) state_d = StRun;
      end
      StRun: begin
        if (testMode_q) begin
          if (!enable) begin
            state_d = StIdle;
          end else begin
            sample     = ramp_q;
            sampleSync = (ramp_q == 16'h0000);
            ramp_d     = ramp_q + 16'd1;
          end
        end else if (half_q) begin
          sample     = head[31:16];
          rdEn       = 1'b1;
          half_d     = 1'b0;
          prevLast_d = head[32];
          if (!enable) state_d = StIdle;
        end else if (!enable) begin
          state_d = StIdle;
        end else if (count_q == '0) begin
          if (under_q != 32'hFFFF_FFFF) under_d = under_q + 32'd1;
        end else begin
          sample     = head[15:0];
          sampleSync = first_q || prevLast_q;
          first_d    = 1'b0;
          half_d     = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    riseNext = '0;
    fallNext = '0;
    for (int i = 0; i < 8; i++) begin
      riseNext[i] = sample[2*i];
      fallNext[i] = sample[2*i+1];
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      tready_q   <= 1'b0;
      state_q    <= StIdle;
      half_q     <= 1'b0;
      first_q    <= 1'b1;
      prevLast_q <= 1'b0;
      testMode_q <= 1'b0;
      ramp_q     <= 16'h0000;
      under_q    <= 32'd0;
      rise_q     <= 8'h00;
      fall_q     <= 8'h00;
      sync_q     <= 1'b0;
    end else begin
      if (wrEn) wrPtr_q <= wrPtr_q + 1'b1;
      if (rdEn) rdPtr_q <= rdPtr_q + 1'b1;
      count_q    <= count_d;
      tready_q   <= (count_d != DepthCnt);
      state_q    <= state_d;
      half_q     <= half_d;
      first_q    <= first_d;
      prevLast_q <= prevLast_d;
      testMode_q <= testMode_d;
      ramp_q     <= ramp_d;
      under_q    <= under_d;
      rise_q     <= riseNext;
      fall_q     <= fallNext;
      sync_q     <= sampleSync;
    end
  end

  assign s00_axis_tready = tready_q;
  assign dout_rise       = rise_q;
  assign dout_fall       = fall_q;
  assign sync_out        = sync_q;
  assign running         = (state_q == StRun);
  assign underflow_cnt   = under_q;

endmodule

// File: tb/tb_adc16dv160_output_emulator.sv
// Directed bench for adc16dv160_output_emulator: a queue-based sample model checked every
// cycle, plus hand-computed literal expectations at key points of each scenario.
module tb_adc16dv160_output_emulator;

  localparam int Depth = 16;
  localparam int Prime = 4;
  localparam int MIdle = 0, MPrime = 1, MRun = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic        tlast;
  logic        enable;
  logic        testMode;
  logic [15:0] idleValue;
  logic [7:0]  doutRise, doutFall;
  logic        syncOut, runningOut;
  logic [31:0] underCnt;

  int nChecks = 0;
  int nFail   = 0;

  adc16dv160_output_emulator #(.FIFO_DEPTH(Depth), .PRIME_LEVEL(Prime)) dut (
    .s00_axis_aclk   (clk),
    .s00_axis_aresetn(rst_n),
    .s00_axis_tvalid (tvalid),
    .s00_axis_tready (tready),
    .s00_axis_tdata  (tdata),
    .s00_axis_tlast  (tlast),
    .enable          (enable),
    .test_mode       (testMode),
    .idle_value      (idleValue),
    .dout_rise       (doutRise),
    .dout_fall       (doutFall),
    .sync_out        (syncOut),
    .running         (runningOut),
    .underflow_cnt   (underCnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] riseOf(input logic [15:0] s);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i] = s[2*i];
    return r;
  endfunction

  function automatic logic [7:0] fallOf(input logic [15:0] s);
    logic [7:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) f[i] = s[2*i+1];
    return f;
  endfunction

  function automatic logic [15:0] sampleOf(input logic [7:0] r, input logic [7:0] f);
    logic [15:0] s;
    for (int i = 0; i < 8; i++) begin
      s[2*i]   = r[i];
      s[2*i+1] = f[i];
    end
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      if (nFail <= 30) $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: word queue plus the sample-slot rules, advanced once per clock.
  logic [32:0] q[$];
  int          mState;
  bit          mTest, mHigh, mFirst, mPrevLast, mAccepted;
  logic [15:0] mRamp;
  logic [7:0]  expRise, expFall;
  bit          expSync, expRunning, expTready;
  logic [31:0] expUnder;

  always @(posedge clk or negedge rst_n) begin
    logic [15:0] smp;
    bit sy, push, pop;
    if (!rst_n) begin
      q.delete();
      mState = MIdle; mTest = 0; mHigh = 0; mFirst = 1; mPrevLast = 0; mAccepted = 0;
      mRamp = 0; expRise = 0; expFall = 0; expSync = 0; expRunning = 0; expTready = 0;
      expUnder = 0;
    end else begin
      push = tvalid && expTready;
      pop  = 0;
      smp  = idleValue;
      sy   = 0;
      if (mState != MRun) begin
        mRamp  = 0;
        mFirst = 1;
      end
      if (mState == MIdle) begin
        if (enable) begin
          mTest  = testMode;
          mState = testMode ? MRun : MPrime;
        end
      end else if (mState == MPrime) begin
        if (!enable) mState = MIdle;
        else if (q.size() >= Prime) mState = MRun;
      end else if (mTest) begin
        if (!enable) mState = MIdle;
        else begin
          smp = mRamp;
          sy = (mRamp == 0);
          mRamp = mRamp + 1;
        end
      end else if (mHigh) begin
        smp = q[0][31:16];
        mPrevLast = q[0][32];
        pop = 1;
        mHigh = 0;
        if (!enable) mState = MIdle;
      end else if (!enable) begin
        mState = MIdle;
      end else if (q.size() == 0) begin
        if (expUnder != 32'hFFFF_FFFF) expUnder = expUnder + 1;
      end else begin
        smp = q[0][15:0];
        sy = mFirst || mPrevLast;
        mFirst = 0;
        mHigh = 1;
      end
      if (pop) void'(q.pop_front());
      if (push) q.push_back({tlast, tdata});
      mAccepted  = push;
      expTready  = (q.size() < Depth);
      expRise    = riseOf(smp);
      expFall    = fallOf(smp);
      expSync    = sy;
      expRunning = (mState == MRun);
    end
  end

  // Every cycle, all outputs against the model.
  always @(negedge clk) begin
    checkOutput("dout_rise", {24'h0, doutRise}, {24'h0, expRise});
    checkOutput("dout_fall", {24'h0, doutFall}, {24'h0, expFall});
    checkOutput("sync_out", {31'h0, syncOut}, {31'h0, expSync});
    checkOutput("running", {31'h0, runningOut}, {31'h0, expRunning});
    checkOutput("tready", {31'h0, tready}, {31'h0, expTready});
    checkOutput("underflow_cnt", underCnt, expUnder);
  end

  task automatic applyStimulus(input logic [31:0] data, input bit last);
    bit done;
    done   = 0;
    tvalid = 1'b1;
    tdata  = data;
    tlast  = last;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (mAccepted) done = 1;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    if (!done) checkOutput("pushTimeout", 32'h0, 32'h1);
  endtask

  task automatic waitSync();
    bit seen;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (syncOut) seen = 1;
    end
    if (!seen) checkOutput("syncTimeout", 32'h0, 32'h1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int syncCount;
    bit seen;
    rst_n = 1'b0; tvalid = 1'b0; tdata = '0; tlast = 1'b0;
    enable = 1'b0; testMode = 1'b0; idleValue = 16'h8000;
    cycles(3);
    checkOutput("resetRise", {24'h0, doutRise}, 32'h0);
    checkOutput("resetTready", {31'h0, tready}, 32'h0);
    rst_n = 1'b1;
    cycles(2);

    $display("[TB] basic stream of samples 1..8");
    applyStimulus(32'h0002_0001, 0);
    applyStimulus(32'h0004_0003, 0);
    applyStimulus(32'h0006_0005, 0);
    applyStimulus(32'h0008_0007, 0);
    enable = 1'b1;
    waitSync();
    checkOutput("firstRise", {24'h0, doutRise}, 32'h01);
    checkOutput("firstFall", {24'h0, doutFall}, 32'h00);
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      checkOutput("seqSample", {16'h0, sampleOf(doutRise, doutFall)}, k);
      checkOutput("seqNoSync", {31'h0, syncOut}, 32'h0);
      checkOutput("seqNoUnder", underCnt, 32'h0);
    end
    cycles(3);
    enable = 1'b0;
    cycles(3);

    $display("[TB] priming threshold, drain and resume");
    applyStimulus(32'h0022_0021, 0);
    applyStimulus(32'h0024_0023, 0);
    enable = 1'b1;
    cycles(4);
    checkOutput("primeRunning", {31'h0, runningOut}, 32'h0);
    checkOutput("primeIdle", {16'h0, sampleOf(doutRise, doutFall)}, 32'h8000);
    applyStimulus(32'h0026_0025, 0);
    applyStimulus(32'h0028_0027, 0);
    waitSync();
    checkOutput("primeFirst", {16'h0, sampleOf(doutRise, doutFall)}, 32'h0021);
    cycles(10);
    idleValue = 16'h1234;
    cycles(5);
    checkOutput("drainIdle", {16'h0, sampleOf(doutRise, doutFall)}, 32'h1234);
    applyStimulus(32'hBBBB_AAAA, 0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (sampleOf(doutRise, doutFall) == 16'hAAAA) seen = 1;
      else @(negedge clk);
    end
    checkOutput("resumeLow", {31'h0, seen}, 32'h1);
    @(negedge clk);
    checkOutput("resumeHigh", {16'h0, sampleOf(doutRise, doutFall)}, 32'hBBBB);
    enable = 1'b0;
    cycles(3);

    $display("[TB] frame sync after tlast");
    applyStimulus(32'h0102_0101, 0);
    applyStimulus(32'h0202_0201, 1);
    applyStimulus(32'h0302_0301, 0);
    applyStimulus(32'h0402_0401, 0);
    enable = 1'b1;
    syncCount = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (syncOut) syncCount++;
    end
    checkOutput("frameSyncCount", syncCount, 32'd2);
    enable = 1'b0;
    cycles(3);

    $display("[TB] ramp test mode with retained FIFO words");
    applyStimulus(32'h0702_0701, 0);
    applyStimulus(32'h0704_0703, 0);
    testMode = 1'b1;
    enable = 1'b1;
    waitSync();
    checkOutput("rampStart", {16'h0, sampleOf(doutRise, doutFall)}, 32'h0000);
    testMode = 1'b0;
    cycles(65535);
    checkOutput("rampTop", {16'h0, sampleOf(doutRise, doutFall)}, 32'hFFFF);
    checkOutput("rampTopSync", {31'h0, syncOut}, 32'h0);
    @(negedge clk);
    checkOutput("rampWrap", {16'h0, sampleOf(doutRise, doutFall)}, 32'h0000);
    checkOutput("rampWrapSync", {31'h0, syncOut}, 32'h1);
    enable = 1'b0;
    cycles(3);
    applyStimulus(32'h0706_0705, 0);
    applyStimulus(32'h0708_0707, 0);
    enable = 1'b1;
    waitSync();
    checkOutput("retainedFirst", {16'h0, sampleOf(doutRise, doutFall)}, 32'h0701);
    cycles(12);
    enable = 1'b0;
    cycles(3);

    $display("[TB] full FIFO, mid-word disable, reset in RUN");
    for (int i = 0; i < Depth; i++)
      applyStimulus({16'h5001 + 16'(2*i), 16'h5000 + 16'(2*i)}, (i % 5) == 4);
    tvalid = 1'b1;
    tdata  = 32'h6001_6000;
    tlast  = 1'b0;
    @(negedge clk);
    checkOutput("fullTready", {31'h0, tready}, 32'h0);
    @(negedge clk);
    checkOutput("fullTreadyHeld", {31'h0, tready}, 32'h0);
    enable = 1'b1;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (mAccepted) seen = 1;
    end
    tvalid = 1'b0;
    checkOutput("fullAcceptLater", {31'h0, seen}, 32'h1);
    cycles(3);
    enable = 1'b0;
    cycles(4);
    enable = 1'b1;
    cycles(6);
    enable = 1'b0;
    cycles(4);
    enable = 1'b1;
    cycles(5);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rstRise", {24'h0, doutRise}, 32'h0);
    checkOutput("rstFall", {24'h0, doutFall}, 32'h0);
    checkOutput("rstSync", {31'h0, syncOut}, 32'h0);
    checkOutput("rstRunning", {31'h0, runningOut}, 32'h0);
    checkOutput("rstUnder", underCnt, 32'h0);
    checkOutput("rstTready", {31'h0, tready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(6);
    checkOutput("postRstPrime", {31'h0, runningOut}, 32'h0);
    enable = 1'b0;
    cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
